// File: rtl/cic_interp_pkg.sv
// Shared SDR constants for the CIC interpolator and decimator.
// Also holds the stage-mode selector and the ratio clamp helper.
package cic_interp_pkg;

  localparam int unsigned CIC_STAGES = 4;
  localparam int unsigned CIC_WIDTH  = 64;
  localparam int unsigned CIC_IN_W   = 8;
  localparam int unsigned CIC_OUT_W  = 8;
  localparam int unsigned RATIO_W    = 16;
  localparam int unsigned SHIFT_W    = 6;

  localparam logic [RATIO_W-1:0] RATIO_MIN = 16'd2;

  typedef enum logic {
    MODE_COMB  = 1'b0,
    MODE_INTEG = 1'b1
  } stage_mode_e;

  function automatic logic [RATIO_W-1:0] clamp_ratio(
    input logic [RATIO_W-1:0] r
  );
    return (r < RATIO_MIN) ? RATIO_MIN : r;
  endfunction

endpackage

// File: rtl/cic_interp_if.sv
// Sample-pull bus between the interpolator and its upstream source.
// The source drives d_in and consumes d_req/d_out.
interface cic_interp_if #(
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned OUT_WIDTH = 8
) ();

  logic [IN_WIDTH-1:0]  d_in;
  logic                 d_req;
  logic [OUT_WIDTH-1:0] d_out;

  modport master (
    output d_in,
    input  d_req,
    input  d_out
  );

  modport slave (
    input  d_in,
    output d_req,
    output d_out
  );

endinterface

// File: rtl/cic_interp_stage.sv
// One CIC section element: enabled comb (delay 1) or accumulator.
// All arithmetic wraps modulo 2^width.
module cic_stage
  import cic_interp_pkg::*;
#(
  parameter stage_mode_e MODE  = MODE_COMB,
  parameter int unsigned width = CIC_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [width-1:0] x_i,
  output logic [width-1:0] y_o
);

  logic [width-1:0] acc_q;
  logic [width-1:0] acc_d;

  if (MODE == MODE_COMB) begin : g_comb
    logic [width-1:0] dly_q;
    logic [width-1:0] dly_d;

    always_comb begin
      acc_d = acc_q;
      dly_d = dly_q;
      if (en_i) begin
        acc_d = x_i - dly_q;
        dly_d = x_i;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) dly_q <= '0;
      else     dly_q <= dly_d;
    end
  end else begin : g_integ
    always_comb begin
      acc_d = acc_q;
      if (en_i) acc_d = acc_q + x_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign y_o = acc_q;

endmodule

// File: rtl/cic_interp.sv
// N-stage CIC interpolator: combs at input rate, zero-stuff, integrators.
// Pulls one sample per R cycles via d_req and emits one sample per clk.
module cic_interp
  import cic_interp_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = CIC_IN_W,
  parameter int unsigned OUT_WIDTH = CIC_OUT_W,
  parameter int unsigned STAGES    = CIC_STAGES,
  parameter int unsigned width     = CIC_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [RATIO_W-1:0] interpolation_ratio,
  input  logic [SHIFT_W-1:0] out_shift,
  cic_interp_if.slave        bus
);

  logic [RATIO_W-1:0]   cnt_q, cnt_d;
  logic [RATIO_W-1:0]   ratio_q, ratio_d;
  logic [STAGES-1:0]    en_dly_q;
  logic [STAGES:0]      en_vec;
  logic [OUT_WIDTH-1:0] dout_q, dout_d;
  logic                 req;
  logic                 wrap;

  logic [width-1:0] comb_w  [STAGES+1];
  logic [width-1:0] integ_w [STAGES+1];

  assign req  = (cnt_q == '0) && !rst;
  assign wrap = (cnt_q == ratio_q - 16'd1);

  // New R takes effect only at the period boundary
  always_comb begin
    cnt_d   = cnt_q + 16'd1;
    ratio_d = ratio_q;
    if (wrap) begin
      cnt_d   = '0;
      ratio_d = clamp_ratio(interpolation_ratio);
    end
  end

  // Slice via shift so an oversized out_shift yields zeros, never X
  always_comb begin
    dout_d = OUT_WIDTH'(integ_w[STAGES] >> out_shift);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      ratio_q  <= clamp_ratio(interpolation_ratio);
      en_dly_q <= '0;
      dout_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      ratio_q  <= ratio_d;
      en_dly_q <= {en_dly_q[STAGES-2:0], req};
      dout_q   <= dout_d;
    end
  end

  assign en_vec = {en_dly_q, req};

  assign comb_w[0] = {{(width-IN_WIDTH){bus.d_in[IN_WIDTH-1]}}, bus.d_in};

  for (genvar k = 1; k <= STAGES; k++) begin : g_comb
    cic_stage #(
      .MODE  (MODE_COMB),
      .width (width)
    ) u_stage (
      .clk  (clk),
      .rst  (rst),
      .en_i (en_vec[k-1]),
      .x_i  (comb_w[k-1]),
      .y_o  (comb_w[k])
    );
  end

  assign integ_w[0] = en_vec[STAGES] ? comb_w[STAGES] : '0;

  for (genvar k = 1; k <= STAGES; k++) begin : g_integ
    cic_stage #(
      .MODE  (MODE_INTEG),
      .width (width)
    ) u_stage (
      .clk  (clk),
      .rst  (rst),
      .en_i (1'b1),
      .x_i  (integ_w[k-1]),
      .y_o  (integ_w[k])
    );
  end

  assign bus.d_req = req;
  assign bus.d_out = dout_q;

endmodule

// File: tb/tb_cic_interp.sv
// Self-checking bench for cic_interp: table of DC cases, hand sequences,
// and randomized runs against a convolution-based reference model.
module tb_cic_interp;
  import cic_interp_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ratio = 16'd16;
  logic [5:0]  shift = 6'd0;

  cic_interp_if #(.IN_WIDTH(8), .OUT_WIDTH(8)) bus ();

  cic_interp dut (
    .clk                 (clk),
    .rst                 (rst),
    .interpolation_ratio (ratio),
    .out_shift           (shift),
    .bus                 (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] r;
    logic [5:0]  sh;
    logic [7:0]  din;
    logic [7:0]  exp_out;
  } dc_vec_t;

  dc_vec_t dc_tab[6];

  longint h[$];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reset for a few cycles; returns at posedge+1 of cycle 0 after release
  task automatic release_rst();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Impulse response of the N=4 CIC at rate r: boxcar of length r, 4 times
  task automatic build_h(input int r);
    longint t[$];
    longint s;
    h = {};
    h.push_back(1);
    repeat (4) begin
      t = {};
      for (int i = 0; i < h.size() + r - 1; i++) begin
        s = 0;
        for (int j = 0; j < r; j++)
          if (i - j >= 0 && i - j < h.size()) s += h[i-j];
        t.push_back(s);
      end
      h = t;
    end
  endtask

  initial begin
    longint imp[13] = '{1, 4, 10, 20, 31, 40, 44, 40, 31, 20, 10, 4, 1};
    int     pulses[$];
    int     exp_p[$];
    int     bad;
    int     glitch;
    int     settle;
    int     v;
    int     r;
    logic [7:0] last;

    dc_tab[0] = '{16'd16, 6'd12, 8'h40, 8'h40};
    dc_tab[1] = '{16'd16, 6'd12, 8'h80, 8'h80};
    dc_tab[2] = '{16'd8,  6'd9,  8'h40, 8'h40};
    dc_tab[3] = '{16'd4,  6'd6,  8'hC0, 8'hC0};
    dc_tab[4] = '{16'd2,  6'd3,  8'h7F, 8'h7F};
    dc_tab[5] = '{16'd16, 6'd12, 8'h01, 8'h01};

    // Reset behaviour
    bus.d_in = 8'h7F;
    rst = 1'b1;
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_dout", longint'(bus.d_out), 0);
      chk("rst_dreq", longint'(bus.d_req), 0);
      next_cycle();
    end
    rst = 1'b0;
    @(negedge clk);
    chk("first_req", longint'(bus.d_req), 1);
    next_cycle();

    // Request rate at R=16
    ratio = 16'd16;
    bus.d_in = 8'h00;
    release_rst();
    pulses = {};
    for (int n = 0; n < 1024; n++) begin
      @(negedge clk);
      if (bus.d_req) pulses.push_back(n);
      next_cycle();
    end
    chk("rate_count", pulses.size(), 64);
    bad = 0;
    for (int i = 0; i < pulses.size(); i++)
      if (pulses[i] != i * 16) bad++;
    chk("rate_spacing", bad, 0);

    // Impulse at R=4, shift 0
    ratio = 16'd4;
    shift = 6'd0;
    release_rst();
    for (int n = 0; n < 40; n++) begin
      bus.d_in = (n == 0) ? 8'h01 : 8'h00;
      @(negedge clk);
      chk($sformatf("impulse_n%0d", n), longint'($signed(bus.d_out)),
          (n >= 9 && n < 22) ? imp[n-9] : 0);
      next_cycle();
    end

    // DC table: settle value and no sign-crossing transient
    foreach (dc_tab[c]) begin
      ratio = dc_tab[c].r;
      shift = dc_tab[c].sh;
      bus.d_in = dc_tab[c].din;
      r = int'(dc_tab[c].r);
      settle = 9 + (r - 1) * 4 + 1 + r;
      glitch = 0;
      bad = 0;
      release_rst();
      for (int n = 0; n < settle + 2 * r; n++) begin
        @(negedge clk);
        v = int'($signed(bus.d_out));
        if ($signed(dc_tab[c].exp_out) >= 0) begin
          if (v < 0 || v > int'($signed(dc_tab[c].exp_out))) glitch++;
        end else begin
          if (v > 0 || v < int'($signed(dc_tab[c].exp_out))) glitch++;
        end
        if (n >= settle && bus.d_out != dc_tab[c].exp_out) bad++;
        last = bus.d_out;
        next_cycle();
      end
      chk($sformatf("dc%0d_glitch", c), glitch, 0);
      chk($sformatf("dc%0d_hold", c), bad, 0);
      chk($sformatf("dc%0d_final", c), longint'(last),
          longint'(dc_tab[c].exp_out));
    end

    // Reset pulsed mid-stream
    ratio = 16'd16;
    shift = 6'd12;
    bus.d_in = 8'h40;
    release_rst();
    repeat (150) next_cycle();
    @(negedge clk);
    chk("mid_pre_dout", longint'(bus.d_out), 64);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_dreq", longint'(bus.d_req), 0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_post_dout", longint'(bus.d_out), 0);
    chk("mid_post_dreq", longint'(bus.d_req), 1);
    next_cycle();

    // Ratio change mid-period, then clamp of R=1
    ratio = 16'd16;
    bus.d_in = 8'h00;
    release_rst();
    pulses = {};
    for (int n = 0; n < 70; n++) begin
      if (n == 21) ratio = 16'd8;
      if (n == 50) ratio = 16'd1;
      @(negedge clk);
      if (bus.d_req) pulses.push_back(n);
      next_cycle();
    end
    exp_p = {0, 16, 32, 40, 48, 56};
    for (int t = 58; t < 70; t += 2) exp_p.push_back(t);
    chk("ratio_count", pulses.size(), exp_p.size());
    bad = 0;
    foreach (exp_p[i])
      if (i >= pulses.size() || pulses[i] != exp_p[i]) bad++;
    chk("ratio_times", bad, 0);

    // Randomized runs against the convolution reference model
    for (int run = 0; run < 4; run++) begin
      longint xs[$];
      longint y;
      logic [7:0] e8;
      logic [7:0] din;
      int k;
      r = int'($urandom_range(8, 2));
      ratio = 16'(r);
      shift = 6'($urandom_range(12, 0));
      build_h(r);
      xs = {};
      release_rst();
      for (int n = 0; n < 200; n++) begin
        din = 8'($urandom);
        bus.d_in = din;
        if (n % r == 0) xs.push_back(longint'($signed(din)));
        y = 0;
        foreach (xs[m]) begin
          k = n - 9 - m * r;
          if (k >= 0 && k < h.size()) y += xs[m] * h[k];
        end
        e8 = 8'(y >>> shift);
        @(negedge clk);
        chk($sformatf("rnd%0d_req_n%0d", run, n),
            longint'(bus.d_req), (n % r == 0) ? 1 : 0);
        chk($sformatf("rnd%0d_out_n%0d", run, n),
            longint'(bus.d_out), longint'(e8));
        next_cycle();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
